// File: rtl/fetch_pkg.sv
// Shared types and constants for the prefetching fetch stage.
// Entries carry a full 32-bit pc/insn; the top casts to its own widths.
package fetch_pkg;

    localparam int ENTRY_AWIDTH = 32;
    localparam int ENTRY_DWIDTH = 32;
    localparam int INSN_ALIGN   = 2;
    localparam int PC_STEP      = 4;

    typedef struct packed {
        logic [ENTRY_AWIDTH-1:0] pc;
        logic [ENTRY_DWIDTH-1:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two FIFO of fetch entries with flush; used both for pending
// request addresses and for the fetched-instruction buffer.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is allowed when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch.sv
// Prefetching fetch stage: sequential requests, in-order responses, a
// DEPTH-entry instruction buffer and redirect with stale-response dropping.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int                DWIDTH   = 32,
    parameter int                AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000),
    parameter int                DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              insn_valid_o,
    input  logic              insn_ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [AWIDTH-1:0] fetch_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     buf_count;
    logic [CW-1:0]     addr_count;
    logic [CW:0]       credit_used;

    fetch_entry_t addr_entry;
    fetch_entry_t addr_head;
    fetch_entry_t buf_entry;
    fetch_entry_t buf_head;

    logic req_fire;
    logic rsp_fire;
    logic rsp_keep;
    logic pop_fire;
    logic buf_empty;
    logic buf_full;
    logic addr_empty;
    logic addr_full;
    logic unused_bits;

    // Every accepted request reserves a buffer slot, so a push never overflows.
    assign credit_used      = {1'b0, outstanding} + {1'b0, buf_count};
    assign imem_req_valid_o = !redirect_i && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr_o      = fetch_pc;

    assign req_fire = imem_req_valid_o && imem_req_ready_i;
    assign rsp_fire = imem_rsp_valid_i && (outstanding != '0);
    assign rsp_keep = rsp_fire && (drop_cnt == '0) && !redirect_i;
    assign pop_fire = insn_valid_o && insn_ready_i;

    assign addr_entry = '{pc: ENTRY_AWIDTH'(fetch_pc), insn: '0};
    assign buf_entry  = '{pc: addr_head.pc, insn: ENTRY_DWIDTH'(imem_rsp_data_i)};

    // Dropped responses still retire their address so the queue stays aligned.
    fetch_fifo #(.DEPTH(DEPTH)) u_addr_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_fire),
        .push_data (addr_entry),
        .pop       (rsp_fire),
        .flush     (1'b0),
        .head      (addr_head),
        .full      (addr_full),
        .empty     (addr_empty),
        .count     (addr_count)
    );

    fetch_fifo #(.DEPTH(DEPTH)) u_insn_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_keep),
        .push_data (buf_entry),
        .pop       (pop_fire),
        .flush     (redirect_i),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign insn_valid_o = !buf_empty;
    assign pc_o         = AWIDTH'(buf_head.pc);
    assign insn_o       = DWIDTH'(buf_head.insn);

    // On redirect, everything still in flight after this cycle's response is stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= BASEADDR;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
            if (redirect_i) begin
                fetch_pc <= {redirect_pc_i[AWIDTH-1:INSN_ALIGN], {INSN_ALIGN{1'b0}}};
                drop_cnt <= outstanding - CW'(rsp_fire);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + AWIDTH'(PC_STEP);
                end
                if (rsp_fire && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    assign unused_bits = ^{addr_head.insn, addr_full, addr_empty, addr_count, buf_full};

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with a fixed-latency in-order memory model
// (data = address ^ 32'hFFFF).
module tb_fetch_prefetch;

    localparam logic [31:0] BASE = 32'h0100_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b1;
    logic [31:0] addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        insn_valid;
    logic        insn_ready = 1'b1;
    logic [31:0] pc;
    logic [31:0] insn;

    req_t        pend[$];
    int          k = 1;
    int          cyc = 0;
    int          check_count = 0;
    int          error_count = 0;

    logic        obs_req_valid;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic [31:0] obs_insn;
    int          obs_cycle;

    fetch_prefetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (req_ready),
        .imem_addr_o      (addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .insn_valid_o     (insn_valid),
        .insn_ready_i     (insn_ready),
        .pc_o             (pc),
        .insn_o           (insn)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive the due response, sample outputs mid-cycle, record accepted requests.
    task automatic applyStimulus();
        req_t r;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r         = pend.pop_front();
            rsp_valid = 1'b1;
            rsp_data  = r.addr ^ 32'h0000_FFFF;
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
        #1;
        obs_req_valid = req_valid;
        obs_addr      = addr;
        obs_valid     = insn_valid;
        obs_pc        = pc;
        obs_insn      = insn;
        obs_cycle     = cyc;
        if (req_valid && req_ready) begin
            pend.push_back('{addr: addr, due: cyc + k});
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        req_ready   = 1'b1;
        insn_ready  = 1'b1;
        pend.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 1;
    endtask

    initial begin
        int n;
        int reqs;
        logic found;

        // Reset values
        @(negedge clk);
        #1;
        checkOutput("reset_valid", {31'b0, insn_valid}, 32'd0);
        checkOutput("reset_pc", pc, 32'd0);
        checkOutput("reset_insn", insn, 32'd0);

        // Streaming with k = 1, decode always ready
        apply_reset();
        k = 1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus();
            if (c == 0) begin
                checkOutput("first_req_valid", {31'b0, obs_req_valid}, 32'd1);
                checkOutput("first_req_addr", obs_addr, BASE);
            end
            if (obs_valid) begin
                if (n == 0) checkOutput("stream_first_cycle", obs_cycle, 32'd3);
                checkOutput("stream_pc", obs_pc, BASE + 32'(4 * n));
                checkOutput("stream_insn", obs_insn, (BASE + 32'(4 * n)) ^ 32'h0000_FFFF);
                n++;
            end
        end
        checkOutput("stream_count", n, 32'd10);

        // Backpressure: buffer fills, requests stop, then drains in order
        apply_reset();
        insn_ready = 1'b0;
        reqs = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus();
            if (obs_req_valid) reqs++;
        end
        checkOutput("bp_req_count", reqs, 32'd4);
        checkOutput("bp_req_stalled", {31'b0, obs_req_valid}, 32'd0);
        checkOutput("bp_head_valid", {31'b0, obs_valid}, 32'd1);
        checkOutput("bp_head_pc", obs_pc, BASE);
        insn_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus();
            if (obs_valid) begin
                checkOutput("bp_drain_pc", obs_pc, BASE + 32'(4 * n));
                n++;
            end
        end
        checkOutput("bp_drain_count", n, 32'd12);

        // Redirect with three responses in flight (k = 3)
        apply_reset();
        k = 3;
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            checkOutput("redir_pre_valid", {31'b0, obs_valid}, 32'd0);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0200_0002;
        applyStimulus();
        checkOutput("redir_no_req", {31'b0, obs_req_valid}, 32'd0);
        redirect = 1'b0;
        found = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus();
            if (c == 0) begin
                checkOutput("redir_req_valid", {31'b0, obs_req_valid}, 32'd1);
                checkOutput("redir_req_addr", obs_addr, 32'h0200_0000);
            end
            if (obs_valid) begin
                if (!found) checkOutput("redir_first_cycle", obs_cycle, 32'd9);
                found = 1'b1;
                checkOutput("redir_pc", obs_pc, 32'h0200_0000 + 32'(4 * n));
                n++;
            end
        end
        checkOutput("redir_seen", {31'b0, found}, 32'd1);

        // Redirect coinciding with a response and a pop
        apply_reset();
        k = 1;
        repeat (6) applyStimulus();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        applyStimulus();
        checkOutput("rrp_pop_valid", {31'b0, obs_valid}, 32'd1);
        checkOutput("rrp_pop_pc", obs_pc, BASE + 32'd16);
        redirect = 1'b0;
        applyStimulus();
        checkOutput("rrp_empty_next", {31'b0, obs_valid}, 32'd0);
        checkOutput("rrp_req_addr", obs_addr, 32'h0000_0100);
        applyStimulus();
        checkOutput("rrp_empty_2", {31'b0, obs_valid}, 32'd0);
        applyStimulus();
        checkOutput("rrp_target_valid", {31'b0, obs_valid}, 32'd1);
        checkOutput("rrp_target_pc", obs_pc, 32'h0000_0100);
        checkOutput("rrp_target_insn", obs_insn, 32'h0000_FEFF);

        // PC wraparound
        apply_reset();
        k = 1;
        repeat (2) applyStimulus();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        applyStimulus();
        redirect = 1'b0;
        applyStimulus();
        checkOutput("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
        applyStimulus();
        checkOutput("wrap_addr1", obs_addr, 32'h0000_0000);
        applyStimulus();
        checkOutput("wrap_pc0", obs_pc, 32'hFFFF_FFFC);
        applyStimulus();
        checkOutput("wrap_pc1", obs_pc, 32'h0000_0000);

        // Asynchronous reset between clock edges
        apply_reset();
        k = 1;
        repeat (5) applyStimulus();
        #1;
        checkOutput("async_pre_valid", {31'b0, insn_valid}, 32'd1);
        checkOutput("async_pre_pc", pc, BASE + 32'd12);
        #1;
        rst_n     = 1'b0;
        rsp_valid = 1'b0;
        #1;
        checkOutput("async_valid", {31'b0, insn_valid}, 32'd0);
        checkOutput("async_pc", pc, 32'd0);
        pend.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 1;
        applyStimulus();
        checkOutput("async_req_valid", {31'b0, obs_req_valid}, 32'd1);
        checkOutput("async_req_addr", obs_addr, BASE);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised successor to the single-cycle fetch stage. Issues sequential instruction-memory requests through a valid/ready request port and accepts in-order responses. Buffers up to `DEPTH` fetched (pc, insn) pairs and presents them to decode through a valid/ready handshake. Supports a redirect input for branches and jumps, which flushes the buffer and discards stale in-flight responses.

## Interface
- `DWIDTH`, 32: instruction width.
- `AWIDTH`, 32: address/PC width.
- `BASEADDR`, 32'h01000000: PC after reset.
- `DEPTH`, 4: buffer entries and the maximum number of outstanding requests; a power of two, at least 2.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid_o`  out  1  request valid.
- `imem_req_ready_i`  in  1  memory accepts the request.
- `imem_addr_o`  out  AWIDTH  request address; word-aligned.
- `imem_rsp_valid_i`  in  1  response valid; responses return in order, at least 1 cycle after acceptance, with no backpressure.
- `imem_rsp_data_i`  in  DWIDTH  response instruction.
- `redirect_i`  in  1  redirect fetch.
- `redirect_pc_i`  in  AWIDTH  redirect target; bits [1:0] are forced to 0.
- `insn_valid_o`  out  1  buffer head valid.
- `insn_ready_i`  in  1  decode consumes the head.
- `pc_o`  out  AWIDTH  PC of the head.
- `insn_o`  out  DWIDTH  instruction of the head.

## Operation
- **State.** `fetch_pc` holds the next address to request. `outstanding` counts accepted requests not yet answered. `drop_cnt` counts responses still to be discarded. A FIFO of (pc, insn) pairs holds fetched instructions. All counters are `$clog2(DEPTH)+1` bits wide.
- **Issue.** `imem_req_valid_o = !redirect_i && (outstanding + occupancy) < DEPTH`, and `imem_addr_o = fetch_pc`.
  - A request handshake completes when both valid and ready are high.
  - On a handshake, `fetch_pc` advances by 4, wrapping modulo 2^AWIDTH.
  - A side queue stores the address of each accepted request; it is DEPTH entries deep and lives in the same FIFO structure.
- **Response.**
  - If `drop_cnt > 0`: discard the response and decrement `drop_cnt`.
  - Otherwise: push (oldest request address, data) into the buffer.
  - Every response decrements `outstanding`.
  - A response arriving while `outstanding == 0` is a protocol violation and is ignored.
- **Output.** `insn_valid_o = !empty`, and `pc_o`/`insn_o` show the head entry. The head pops on `insn_valid_o && insn_ready_i`.
- **Credit rule.** `outstanding + occupancy` never exceeds `DEPTH`, so a push never finds the buffer full.
- **Redirect** (the cycle `redirect_i` is high):
  - No request is issued.
  - A pop in the same cycle still completes, then all buffer entries are discarded.
  - `fetch_pc` becomes `{redirect_pc_i[AWIDTH-1:2], 2'b00}`.
  - `drop_cnt` becomes the outstanding count after this cycle's response is applied. Any response in the redirect cycle is itself dropped.
  - Back-to-back redirects: the last one wins, and `drop_cnt` accumulates correctly.
- **Simultaneous push and pop on a full buffer** is legal; occupancy is unchanged.

## Timing
- Reset values: `fetch_pc = BASEADDR`; `outstanding`, `drop_cnt` and occupancy are 0; `insn_valid_o = 0`; `pc_o`/`insn_o` are 0 while empty.
- Reset asserted mid-operation clears everything immediately. In-flight responses arriving after release are the environment's responsibility to suppress.
- The first cycle after reset release drives `imem_req_valid_o = 1` with `imem_addr_o = BASEADDR`.
- Latency:
  - Request accepted at cycle t; response at t+k (k ≥ 1); `insn_valid_o` is high at t+k+1.
  - With k = 1 and `insn_ready_i` held high, sustained throughput is one instruction per cycle.
- Redirect in cycle r: the first request for the target is issued at r+1. Its instruction is visible at r+1+k+1 at the earliest.
- `imem_req_valid_o` and `insn_valid_o` do not depend combinationally on their own ready inputs. `imem_req_valid_o` does depend combinationally on `redirect_i`.

## Structure
- Package `fetch_pkg` holds:
  - `fetch_entry_t` (pc, insn packed struct);
  - `INSN_ALIGN = 2`;
  - `PC_STEP = 4`.
- Sub-module `fetch_fifo`: parametrised DEPTH × `fetch_entry_t` FIFO with push, pop, flush, full, empty and count. It is instantiated twice: once for the pending-address queue and once for the instruction buffer.

## Test plan
- **Reset and stream.** Release reset; memory always ready with k = 1 and data = address ^ 32'hFFFF; decode always ready. Required: `pc_o` sequence 01000000, 01000004, 01000008…, one per cycle from cycle 2, with insn = pc ^ 32'hFFFF.
- **Backpressure.** Hold `insn_ready_i = 0` with DEPTH = 4. Required: exactly 4 requests issued, then `imem_req_valid_o` stays 0. Releasing ready drains 4 entries in order and then refills.
- **Redirect with in-flight responses.** Use k = 3 and redirect to 32'h02000002 while 3 requests are outstanding. Required: those 3 responses are dropped, the next request address is 02000000, and the first `pc_o` is 02000000.
- **Redirect plus response plus pop in one cycle.** Required: the popped entry completes, the response is discarded, and the buffer is empty the next cycle.
- **PC wraparound.** Redirect to 32'hFFFFFFFC. Required: the next addresses are FFFFFFFC then 00000000.
- **Async reset mid-stream.** Assert `rst_n = 0` between clock edges. Required: `insn_valid_o = 0` immediately; after release, the first request is to BASEADDR.
